fip_dot_seq: RTL and testbench

//  Sequencer for one add_mult pre-add multiplier that computes a signed dot product
//  sum(a[k]*b[k]) of 2*LEN terms by Winograd fast inner product.
//  Per pair j: P_j = (a1+b0)*(a0+b1). Result = sum(P_j) - corr. corr = sum(a0*a1 + b0*b1) is

---
 rtl/fip_pkg.sv | 20 ++
 rtl/fip_dot_seq_if.sv | 30 +++
 rtl/add_mult.sv | 30 +++
 rtl/pp_sum.sv | 15 +
 rtl/fip_dot_seq.sv | 117 +++++++++++
 tb/tb_fip_dot_seq.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/fip_pkg.sv
// Shared types and derived-size helpers for the fast-inner-product sequencer and
// other add_mult users.
package fip_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fip_state_t;

    // Pre-adder output width: one bit of growth over the wider operand.
    function automatic int unsigned in_mul_size(input int unsigned s0, input int unsigned s1);
        return ((s0 > s1) ? s0 : s1) + 1;
    endfunction

    function automatic int unsigned pp_per_mul();
        return 2;
    endfunction

    function automatic int unsigned pp_size(input int unsigned s0, input int unsigned s1);
        return 2 * in_mul_size(s0, s1);
    endfunction

endpackage

// File: rtl/fip_dot_seq_if.sv
// Job, operand-stream and result handshakes of the dot-product sequencer.
// master = streamer/writeback side, slave = sequencer.
interface fip_dot_seq_if #(
    parameter int unsigned IN_SIZE_0 = 4,
    parameter int unsigned IN_SIZE_1 = 8,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned LEN_W     = 8
);
    logic                        start_i;
    logic [LEN_W-1:0]            len_i;
    logic signed [ACC_W-1:0]     corr_i;
    logic                        busy_o;
    logic                        in_valid_i;
    logic                        in_ready_o;
    logic signed [IN_SIZE_0-1:0] a_i [2];
    logic signed [IN_SIZE_1-1:0] b_i [2];
    logic                        res_valid_o;
    logic                        res_ready_i;
    logic signed [ACC_W-1:0]     res_o;

    modport master (
        output start_i, len_i, corr_i, in_valid_i, a_i, b_i, res_ready_i,
        input  busy_o, in_ready_o, res_valid_o, res_o
    );

    modport slave (
        input  start_i, len_i, corr_i, in_valid_i, a_i, b_i, res_ready_i,
        output busy_o, in_ready_o, res_valid_o, res_o
    );
endinterface

// File: rtl/add_mult.sv
// Pre-add multiplier: (in_0[1]+in_1[0]) * (in_0[0]+in_1[1]) emitted as partial
// products whose sum mod 2^PP_SIZE is the signed product.
module add_mult
    import fip_pkg::*;
#(
    parameter int unsigned IN_SIZE_0 = 4,
    parameter int unsigned IN_SIZE_1 = 8
) (
    input  logic signed [IN_SIZE_0-1:0] in_0_i [2],
    input  logic signed [IN_SIZE_1-1:0] in_1_i [2],
    output logic [pp_size(IN_SIZE_0, IN_SIZE_1)-1:0] pp_o [pp_per_mul()]
);
    localparam int unsigned IN_MUL_SIZE = in_mul_size(IN_SIZE_0, IN_SIZE_1);
    localparam int unsigned PP_SIZE     = pp_size(IN_SIZE_0, IN_SIZE_1);
    localparam int unsigned LO_W        = IN_MUL_SIZE / 2;

    logic signed [IN_MUL_SIZE-1:0] x, y;
    logic signed [PP_SIZE-1:0]     x_w, y_lo_w, y_hi_w;

    // y split into an unsigned low digit and a signed high digit: y = y_hi*2^LO_W + y_lo.
    always_comb begin
        x      = IN_MUL_SIZE'(in_0_i[1]) + IN_MUL_SIZE'(in_1_i[0]);
        y      = IN_MUL_SIZE'(in_0_i[0]) + IN_MUL_SIZE'(in_1_i[1]);
        x_w    = PP_SIZE'(x);
        y_lo_w = PP_SIZE'(y[LO_W-1:0]);
        y_hi_w = PP_SIZE'($signed(y[IN_MUL_SIZE-1:LO_W]));
        pp_o[0] = x_w * y_lo_w;
        pp_o[1] = (x_w * y_hi_w) << LO_W;
    end
endmodule

// File: rtl/pp_sum.sv
// Reduces add_mult partial products to the signed product (mod 2^PP_SIZE).
module pp_sum #(
    parameter int unsigned PP_PER_MUL = 2,
    parameter int unsigned PP_SIZE    = 18
) (
    input  logic [PP_SIZE-1:0]        pp_i [PP_PER_MUL],
    output logic signed [PP_SIZE-1:0] prod_o
);
    always_comb begin
        prod_o = '0;
        for (int i = 0; i < PP_PER_MUL; i++) begin
            prod_o = prod_o + pp_i[i];
        end
    end
endmodule

// File: rtl/fip_dot_seq.sv
// Winograd dot-product sequencer: streams operand pairs through one add_mult,
// accumulates pair products and returns acc - corr.
module fip_dot_seq
    import fip_pkg::*;
#(
    parameter int unsigned IN_SIZE_0 = 4,
    parameter int unsigned IN_SIZE_1 = 8,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned LEN_W     = 8
) (
    input logic             clk_i,
    input logic             rst_ni,
    fip_dot_seq_if.slave    bus
);
    localparam int unsigned PP_PER_MUL = pp_per_mul();
    localparam int unsigned PP_SIZE    = pp_size(IN_SIZE_0, IN_SIZE_1);

    fip_state_t              state_q, state_d;
    logic [LEN_W-1:0]        rem_q, rem_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] corr_q, corr_d;
    logic signed [ACC_W-1:0] res_q, res_d;
    logic [PP_SIZE-1:0]      pp_s0 [PP_PER_MUL];
    logic [PP_SIZE-1:0]      pp_q  [PP_PER_MUL];
    logic                    v1_q;
    logic signed [PP_SIZE-1:0] prod;
    logic                    in_ready;
    logic                    in_fire;

    add_mult #(
        .IN_SIZE_0 (IN_SIZE_0),
        .IN_SIZE_1 (IN_SIZE_1)
    ) u_add_mult (
        .in_0_i (bus.a_i),
        .in_1_i (bus.b_i),
        .pp_o   (pp_s0)
    );

    pp_sum #(
        .PP_PER_MUL (PP_PER_MUL),
        .PP_SIZE    (PP_SIZE)
    ) u_pp_sum (
        .pp_i   (pp_q),
        .prod_o (prod)
    );

    assign in_ready        = (state_q == RUN);
    assign in_fire         = bus.in_valid_i & in_ready;
    assign bus.in_ready_o  = in_ready;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.res_valid_o = (state_q == DONE);
    assign bus.res_o       = res_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        corr_d  = corr_q;
        res_d   = res_q;
        acc_d   = acc_q;
        if (v1_q) begin
            acc_d = acc_q + ACC_W'(prod);
        end
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    rem_d   = bus.len_i;
                    corr_d  = bus.corr_i;
                    acc_d   = '0;
                    state_d = (bus.len_i != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (in_fire) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Nothing is accepted here, so an empty S1 means acc is final.
                if (!v1_q) begin
                    res_d   = acc_q - corr_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rem_q   <= '0;
            corr_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            v1_q    <= 1'b0;
            pp_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            corr_q  <= corr_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            v1_q    <= in_fire;
            if (in_fire) begin
                pp_q <= pp_s0;
            end
        end
    end
endmodule

// File: tb/tb_fip_dot_seq.sv
// Directed bench for fip_dot_seq; expected results go through a scoreboard queue
// checked by an independent monitor on each result handshake.
module tb_fip_dot_seq;
    localparam int unsigned IN_SIZE_0 = 4;
    localparam int unsigned IN_SIZE_1 = 8;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned LEN_W     = 8;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    fip_dot_seq_if #(
        .IN_SIZE_0 (IN_SIZE_0),
        .IN_SIZE_1 (IN_SIZE_1),
        .ACC_W     (ACC_W),
        .LEN_W     (LEN_W)
    ) bus ();

    fip_dot_seq #(
        .IN_SIZE_0 (IN_SIZE_0),
        .IN_SIZE_1 (IN_SIZE_1),
        .ACC_W     (ACC_W),
        .LEN_W     (LEN_W)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int exp_q[$];

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(input int len, input int corr);
        bus.start_i = 1'b1;
        bus.len_i   = 8'(len);
        bus.corr_i  = 32'(corr);
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic send_pair(input int a0, input int a1, input int b0, input int b1);
        bus.a_i[0]     = 4'(a0);
        bus.a_i[1]     = 4'(a1);
        bus.b_i[0]     = 8'(b0);
        bus.b_i[1]     = 8'(b1);
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 20 && !bus.in_ready_o; i++) tick();
        check("pair_ready_timeout", longint'(bus.in_ready_o), 1);
        tick();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_res(input int max_cyc);
        for (int i = 0; i < max_cyc && !bus.res_valid_o; i++) tick();
        check("res_valid_timeout", longint'(bus.res_valid_o), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, longint'(bus.busy_o), 0);
        check({tag, "_in_ready"}, longint'(bus.in_ready_o), 0);
        check({tag, "_res_valid"}, longint'(bus.res_valid_o), 0);
        check({tag, "_res"}, longint'($signed(bus.res_o)), 0);
    endtask

    always @(posedge clk_i) begin
        if (bus.in_valid_i && bus.in_ready_o) n_acc <= n_acc + 1;
    end

    // Monitor: every result handshake pops the oldest expectation.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && bus.res_valid_o && bus.res_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %0d, expected no result",
                             $signed(bus.res_o));
                end else begin
                    check("result", longint'($signed(bus.res_o)), longint'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.start_i     = 1'b0;
        bus.len_i       = '0;
        bus.corr_i      = '0;
        bus.in_valid_i  = 1'b0;
        bus.a_i[0]      = '0;
        bus.a_i[1]      = '0;
        bus.b_i[0]      = '0;
        bus.b_i[1]      = '0;
        bus.res_ready_i = 1'b1;
        #2;
        check_all_zero("reset");
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // 1: single pair, exact result timing
        exp_q.push_back(-2);
        start_job(1, -14);
        check("t1_in_ready", longint'(bus.in_ready_o), 1);
        send_pair(2, 3, 5, -4);
        check("t1_valid_tL1", longint'(bus.res_valid_o), 0);
        tick();
        check("t1_valid_tL2", longint'(bus.res_valid_o), 0);
        tick();
        check("t1_valid_tL3", longint'(bus.res_valid_o), 1);
        check("t1_busy_done", longint'(bus.busy_o), 1);
        tick();
        check("t1_busy_after", longint'(bus.busy_o), 0);

        // 2: pre-add extremes
        exp_q.push_back(2048);
        start_job(1, 16448);
        send_pair(-8, -8, -128, -128);
        wait_res(10);
        tick();
        check("t2_busy_after", longint'(bus.busy_o), 0);

        // 3: empty job
        exp_q.push_back(-5);
        start_job(0, 5);
        check("t3_in_ready_s1", longint'(bus.in_ready_o), 0);
        check("t3_valid_s1", longint'(bus.res_valid_o), 0);
        tick();
        check("t3_valid_s2", longint'(bus.res_valid_o), 1);
        check("t3_in_ready_s2", longint'(bus.in_ready_o), 0);
        tick();
        check("t3_busy_after", longint'(bus.busy_o), 0);

        // 4: bubbles, back-pressure, starts while busy
        exp_q.push_back(8);
        bus.res_ready_i = 1'b0;
        base = n_acc;
        start_job(4, 8);
        for (int k = 0; k < 4; k++) begin
            send_pair(1, 1, 1, 1);
            if (k == 1) begin
                bus.start_i = 1'b1;
                bus.len_i   = 8'd1;
                bus.corr_i  = '0;
            end
            tick();
            bus.start_i = 1'b0;
        end
        wait_res(10);
        for (int k = 0; k < 3; k++) begin
            check("t4_hold_valid", longint'(bus.res_valid_o), 1);
            check("t4_hold_res", longint'($signed(bus.res_o)), 8);
            tick();
        end
        bus.res_ready_i = 1'b1;
        bus.start_i     = 1'b1;
        bus.len_i       = 8'd1;
        tick();
        bus.start_i = 1'b0;
        check("t4_start_at_handshake", longint'(bus.busy_o), 0);
        check("t4_accepts", longint'(n_acc - base), 4);
        tick();
        check("t4_idle", longint'(bus.busy_o), 0);

        // 5: abort by reset mid-job
        start_job(3, 100);
        send_pair(2, 3, 5, -4);
        send_pair(2, 3, 5, -4);
        check("t5_busy_before", longint'(bus.busy_o), 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("t5_abort");
        tick();
        rst_ni = 1'b1;
        tick();
        exp_q.push_back(-2);
        start_job(1, -14);
        send_pair(2, 3, 5, -4);
        wait_res(10);
        tick();
        check("t5_busy_after", longint'(bus.busy_o), 0);

        // 6: back-to-back jobs
        exp_q.push_back(-2);
        exp_q.push_back(2048);
        start_job(1, -14);
        send_pair(2, 3, 5, -4);
        wait_res(10);
        tick();
        start_job(1, 16448);
        check("t6_b_ready", longint'(bus.in_ready_o), 1);
        send_pair(-8, -8, -128, -128);
        wait_res(10);
        tick();

        repeat (3) tick();
        check("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
